// File: rtl/pa_cpu_clic_int_recv_if.sv
// CLIC request/response wires and the vector-table fetch bus seen by the CPU-side
// interrupt receiver. master = CLIC/fetch side, slave = receiver.
interface pa_cpu_clic_int_recv_if #(
   parameter int ID_WIDTH = 12
);
   logic                clic_cpu_int_hv;
   logic [ID_WIDTH-1:0] clic_cpu_int_id;
   logic [7:0]          clic_cpu_int_il;
   logic [1:0]          clic_cpu_int_priv;
   logic [ID_WIDTH-1:0] cpu_clic_curid;
   logic                cpu_clic_int_exit;
   logic [1:0]          cpu_clic_mode;
   logic                vec_req;
   logic [31:0]         vec_addr;
   logic                vec_ack;
   logic [31:0]         vec_rdata;

   modport master (
      output clic_cpu_int_hv, clic_cpu_int_id, clic_cpu_int_il, clic_cpu_int_priv,
      output vec_ack, vec_rdata,
      input  cpu_clic_curid, cpu_clic_int_exit, cpu_clic_mode, vec_req, vec_addr
   );

   modport slave (
      input  clic_cpu_int_hv, clic_cpu_int_id, clic_cpu_int_il, clic_cpu_int_priv,
      input  vec_ack, vec_rdata,
      output cpu_clic_curid, cpu_clic_int_exit, cpu_clic_mode, vec_req, vec_addr
   );
endinterface

// File: rtl/pa_cpu_clic_int_recv.sv
// CPU-side CLIC interrupt receiver: qualifies requests, waits for an instruction
// boundary, fetches hv vector entries, signals the take and keeps the nesting stack.
module pa_cpu_clic_int_recv_chk #(
   parameter int DW         = 3,
   parameter int NEST_DEPTH = 4
) (
   input logic          clk,
   input logic          rst,
   input logic          push,
   input logic          pop,
   input logic [DW-1:0] depth
);
   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (depth == DW'(NEST_DEPTH))));
endmodule

module pa_cpu_clic_int_recv #(
   parameter int NEST_DEPTH = 4,
   parameter int ID_WIDTH   = 12
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   pa_cpu_clic_int_recv_if.slave clic,
   input  logic                  cp0_mie,
   input  logic [31:0]           cp0_mtvt_base,
   input  logic [31:0]           cp0_mtvec_base,
   input  logic                  core_int_ready,
   input  logic                  core_mret,
   output logic                  int_take,
   output logic [ID_WIDTH-1:0]   int_take_id,
   output logic [31:0]           int_take_pc,
   output logic [7:0]            cur_il,
   output logic                  nest_full
);
   localparam int DW     = $clog2(NEST_DEPTH + 1);
   localparam int STK_SZ = 1 << DW;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BND = 2'd1,
      VEC      = 2'd2,
      TAKE     = 2'd3
   } state_t;

   state_t              state_r;
   logic [DW-1:0]       depth_r;
   logic [DW-1:0]       depth_nxt_s;
   logic [ID_WIDTH-1:0] id_stk_r [STK_SZ];
   logic [7:0]          il_stk_r [STK_SZ];
   logic [ID_WIDTH-1:0] top_id_nxt_s;
   logic [7:0]          top_il_nxt_s;
   logic [7:0]          lat_il_r;
   logic [1:0]          blank_r;
   logic                qual_s;
   logic                push_s;
   logic                pop_s;

   logic                int_take_r;
   logic [ID_WIDTH-1:0] int_take_id_r;
   logic [31:0]         int_take_pc_r;
   logic                vec_req_r;
   logic [31:0]         vec_addr_r;
   logic [7:0]          cur_il_r;
   logic [ID_WIDTH-1:0] curid_r;
   logic                nest_full_r;
   logic                exit_r;
   logic [1:0]          mode_r;

   // blank_r covers the exit-pulse cycle and the one after, while the CLIC clears its stale request
   assign qual_s = (clic.clic_cpu_int_il != 8'd0) && (clic.clic_cpu_int_priv == 2'b11) &&
                   (clic.clic_cpu_int_il > cur_il_r) && cp0_mie && !nest_full_r &&
                   (blank_r == 2'd0);
   assign push_s = (state_r == TAKE);
   assign pop_s  = core_mret && (depth_r != {DW{1'b0}});

   // Next stack depth and next top-of-stack {id,il}
   always_comb begin
      depth_nxt_s  = depth_r;
      top_id_nxt_s = curid_r;
      top_il_nxt_s = cur_il_r;
      if (push_s) begin
         top_id_nxt_s = int_take_id_r;
         top_il_nxt_s = lat_il_r;
         if (pop_s) begin
            depth_nxt_s = depth_r;
         end else begin
            depth_nxt_s = depth_r + DW'(1);
         end
      end else if (pop_s) begin
         depth_nxt_s = depth_r - DW'(1);
         if (depth_r > DW'(1)) begin
            top_id_nxt_s = id_stk_r[depth_r - DW'(2)];
            top_il_nxt_s = il_stk_r[depth_r - DW'(2)];
         end else begin
            top_id_nxt_s = {ID_WIDTH{1'b0}};
            top_il_nxt_s = 8'd0;
         end
      end else begin
         depth_nxt_s = depth_r;
      end
   end

   // Nesting stack, registered top-of-stack outputs, exit pulse and blanking window
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         for (int i = 0; i < STK_SZ; i++) begin
            id_stk_r[i] <= {ID_WIDTH{1'b0}};
            il_stk_r[i] <= 8'd0;
         end
         depth_r     <= {DW{1'b0}};
         cur_il_r    <= 8'd0;
         curid_r     <= {ID_WIDTH{1'b0}};
         nest_full_r <= 1'b0;
         exit_r      <= 1'b0;
         blank_r     <= 2'd0;
         mode_r      <= 2'b11;
      end else begin
         if (push_s && pop_s) begin
            id_stk_r[depth_r - DW'(1)] <= int_take_id_r;
            il_stk_r[depth_r - DW'(1)] <= lat_il_r;
         end else if (push_s) begin
            id_stk_r[depth_r] <= int_take_id_r;
            il_stk_r[depth_r] <= lat_il_r;
         end
         depth_r     <= depth_nxt_s;
         cur_il_r    <= top_il_nxt_s;
         curid_r     <= top_id_nxt_s;
         nest_full_r <= (depth_nxt_s == DW'(NEST_DEPTH));
         exit_r      <= pop_s;
         if (pop_s) begin
            blank_r <= 2'd2;
         end else if (blank_r != 2'd0) begin
            blank_r <= blank_r - 2'd1;
         end
         mode_r      <= 2'b11;
      end
   end

   // Request FSM with registered take / vector-fetch outputs
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_r       <= IDLE;
         int_take_r    <= 1'b0;
         int_take_id_r <= {ID_WIDTH{1'b0}};
         int_take_pc_r <= 32'd0;
         lat_il_r      <= 8'd0;
         vec_req_r     <= 1'b0;
         vec_addr_r    <= 32'd0;
      end else begin
         int_take_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (qual_s) begin
                  state_r <= WAIT_BND;
               end
            end
            WAIT_BND: begin
               if (!qual_s) begin
                  state_r <= IDLE;
               end else if (core_int_ready) begin
                  int_take_id_r <= clic.clic_cpu_int_id;
                  lat_il_r      <= clic.clic_cpu_int_il;
                  if (clic.clic_cpu_int_hv) begin
                     state_r    <= VEC;
                     vec_req_r  <= 1'b1;
                     vec_addr_r <= cp0_mtvt_base + 32'({clic.clic_cpu_int_id, 2'b00});
                  end else begin
                     state_r       <= TAKE;
                     int_take_r    <= 1'b1;
                     int_take_pc_r <= cp0_mtvec_base;
                  end
               end
            end
            // Committed: the fetch completes even if the request is withdrawn meanwhile
            VEC: begin
               if (clic.vec_ack) begin
                  vec_req_r     <= 1'b0;
                  int_take_pc_r <= {clic.vec_rdata[31:1], 1'b0};
                  int_take_r    <= 1'b1;
                  state_r       <= TAKE;
               end
            end
            TAKE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign int_take               = int_take_r;
   assign int_take_id            = int_take_id_r;
   assign int_take_pc            = int_take_pc_r;
   assign cur_il                 = cur_il_r;
   assign nest_full              = nest_full_r;
   assign clic.vec_req           = vec_req_r;
   assign clic.vec_addr          = vec_addr_r;
   assign clic.cpu_clic_curid    = curid_r;
   assign clic.cpu_clic_int_exit = exit_r;
   assign clic.cpu_clic_mode     = mode_r;

   pa_cpu_clic_int_recv_chk #(
      .DW         (DW),
      .NEST_DEPTH (NEST_DEPTH)
   ) u_chk (
      .clk   (forever_cpuclk),
      .rst   (cpurst),
      .push  (push_s),
      .pop   (pop_s),
      .depth (depth_r)
   );
endmodule
